// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data memory arbiter and its sub-blocks.
package data_mem_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } arb_state_e;

    localparam logic REQ_PIPE = 1'b0;
    localparam logic REQ_DBG  = 1'b1;

    localparam int unsigned MEM_BYTES_DEFAULT = 200;

    // 65-bit sum so addresses near 2^64 cannot wrap back into range.
    function automatic logic addr_in_range(input logic [63:0] addr, input int unsigned mem_bytes);
        return ({1'b0, addr} + 65'd7) < 65'(mem_bytes);
    endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// One requester port of the data memory arbiter: request handshake plus response strobe.
interface data_mem_arbiter_if;

    logic        valid;
    logic        write;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        ready;
    logic        rsp_valid;
    logic        rsp_err;
    logic [63:0] rdata;

    modport master (
        output valid, write, addr, wdata,
        input  ready, rsp_valid, rsp_err, rdata
    );

    modport slave (
        input  valid, write, addr, wdata,
        output ready, rsp_valid, rsp_err, rdata
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; the requester not granted most recently wins a tie.
module rr_arbiter2
    import data_mem_pkg::*;
#(
    parameter int unsigned RR_FIRST = 0
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last_q;

    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (last_q == REQ_DBG) ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            // Pretend the other side went last so RR_FIRST takes the first tie.
            last_q <= (RR_FIRST == 0) ? REQ_DBG : REQ_PIPE;
        end else if (|gnt) begin
            last_q <= gnt[REQ_DBG];
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates the pipeline MEM stage and the debug/loader port onto one data memory,
// one access every three cycles (IDLE -> ACCESS -> RESP).
module data_mem_arbiter
    import data_mem_pkg::*;
#(
    parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT,
    parameter int unsigned RR_FIRST  = 0
) (
    input  logic               clock,
    input  logic               reset_n,
    data_mem_arbiter_if.slave  p_port,
    data_mem_arbiter_if.slave  d_port,
    output logic [63:0]        Memory_Address,
    output logic [63:0]        Write_Data,
    output logic               MemWrite,
    output logic               MemRead,
    input  logic [63:0]        Read_Data
);

    arb_state_e  state_q;
    logic        write_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic        id_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [63:0] rsp_rdata_q;

    logic [1:0]  gnt;
    logic        arb_enable;
    logic        in_range;
    logic        in_access;

    assign arb_enable = (state_q == StIdle) && reset_n;

    rr_arbiter2 #(
        .RR_FIRST (RR_FIRST)
    ) u_rr_arbiter2 (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (arb_enable),
        .req     ({d_port.valid, p_port.valid}),
        .gnt     (gnt)
    );

    assign in_range  = addr_in_range(addr_q, MEM_BYTES);
    assign in_access = (state_q == StAccess);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            id_q        <= REQ_PIPE;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (|gnt) begin
                        state_q <= StAccess;
                        id_q    <= gnt[REQ_DBG];
                        if (gnt[REQ_DBG]) begin
                            write_q <= d_port.write;
                            addr_q  <= d_port.addr;
                            wdata_q <= d_port.wdata;
                        end else begin
                            write_q <= p_port.write;
                            addr_q  <= p_port.addr;
                            wdata_q <= p_port.wdata;
                        end
                    end
                end
                StAccess: begin
                    state_q     <= StResp;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= !in_range;
                    rsp_rdata_q <= (in_range && !write_q) ? Read_Data : '0;
                end
                StResp: begin
                    state_q     <= StIdle;
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= '0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Strobes are gated by reset_n so a store caught in ACCESS never reaches memory.
    assign Memory_Address = in_access ? addr_q : '0;
    assign Write_Data     = in_access ? wdata_q : '0;
    assign MemWrite       = in_access && reset_n && in_range && write_q;
    assign MemRead        = in_access && reset_n && in_range && !write_q;

    assign p_port.ready     = gnt[REQ_PIPE];
    assign d_port.ready     = gnt[REQ_DBG];

    assign p_port.rsp_valid = rsp_valid_q && (id_q == REQ_PIPE);
    assign p_port.rsp_err   = rsp_valid_q && (id_q == REQ_PIPE) && rsp_err_q;
    assign p_port.rdata     = (rsp_valid_q && (id_q == REQ_PIPE)) ? rsp_rdata_q : '0;

    assign d_port.rsp_valid = rsp_valid_q && (id_q == REQ_DBG);
    assign d_port.rsp_err   = rsp_valid_q && (id_q == REQ_DBG) && rsp_err_q;
    assign d_port.rdata     = (rsp_valid_q && (id_q == REQ_DBG)) ? rsp_rdata_q : '0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed vector table, corner sequences and
// random two-port traffic against a transaction-level reference model.
module tb_data_mem_arbiter;
    import data_mem_pkg::*;

    localparam int unsigned MemBytes = 200;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [63:0] Memory_Address;
    logic [63:0] Write_Data;
    logic [63:0] Read_Data;
    logic        MemWrite;
    logic        MemRead;

    data_mem_arbiter_if p_if ();
    data_mem_arbiter_if d_if ();

    data_mem_arbiter #(
        .MEM_BYTES (MemBytes),
        .RR_FIRST  (0)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .p_port         (p_if),
        .d_port         (d_if),
        .Memory_Address (Memory_Address),
        .Write_Data     (Write_Data),
        .MemWrite       (MemWrite),
        .MemRead        (MemRead),
        .Read_Data      (Read_Data)
    );

    always #5 clock = ~clock;

    // Environment memory: byte array, combinational read, write on rising edge.
    logic [7:0] mem [MemBytes];
    logic       mem_loaded = 1'b0;

    always @(posedge clock) begin
        if (!mem_loaded) begin
            for (int i = 0; i < int'(MemBytes); i++) mem[i] <= 8'(i);
            mem_loaded <= 1'b1;
        end else if (MemWrite && Memory_Address <= 64'(MemBytes - 8)) begin
            for (int k = 0; k < 8; k++) mem[int'(Memory_Address) + k] <= Write_Data[8*k +: 8];
        end
    end

    always_comb begin
        Read_Data = '0;
        if (Memory_Address <= 64'(MemBytes - 8)) begin
            for (int k = 0; k < 8; k++) Read_Data[8*k +: 8] = mem[int'(Memory_Address) + k];
        end
    end

    // Reference model state.
    logic [7:0] ref_mem [MemBytes];
    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic ref_oor(input logic [63:0] a);
        return a > 64'(MemBytes - 8);
    endfunction

    function automatic logic [63:0] ref_read(input logic [63:0] a);
        logic [63:0] v;
        v = '0;
        for (int k = 0; k < 8; k++) v[8*k +: 8] = ref_mem[int'(a) + k];
        return v;
    endfunction

    task automatic ref_write(input logic [63:0] a, input logic [63:0] wd);
        for (int k = 0; k < 8; k++) ref_mem[int'(a) + k] = wd[8*k +: 8];
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic port, input logic v, input logic wr,
                         input logic [63:0] a, input logic [63:0] wd);
        if (port == REQ_DBG) begin
            d_if.valid = v; d_if.write = wr; d_if.addr = a; d_if.wdata = wd;
        end else begin
            p_if.valid = v; p_if.write = wr; p_if.addr = a; p_if.wdata = wd;
        end
    endtask

    function automatic logic port_ready(input logic port);
        return (port == REQ_DBG) ? d_if.ready : p_if.ready;
    endfunction

    function automatic logic [65:0] port_rsp(input logic port);
        if (port == REQ_DBG) return {d_if.rsp_valid, d_if.rsp_err, d_if.rdata};
        return {p_if.rsp_valid, p_if.rsp_err, p_if.rdata};
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        drive(REQ_PIPE, 1'b0, 1'b0, '0, '0);
        drive(REQ_DBG, 1'b0, 1'b0, '0, '0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    // Single transaction from IDLE; called at a falling edge, returns at a falling edge in IDLE.
    task automatic run_txn(input logic port, input logic wr, input logic [63:0] addr,
                           input logic [63:0] wdata, input logic exp_err,
                           input logic [63:0] exp_rdata);
        int waited;
        drive(port, 1'b1, wr, addr, wdata);
        #1;
        waited = 0;
        while (!port_ready(port) && waited < 8) begin
            @(negedge clock);
            #1;
            waited++;
        end
        check("txn_accept", {port_ready(port), port_ready(!port)}, {1'b1, 1'b0});
        @(negedge clock);
        drive(port, 1'b0, 1'b0, '0, '0);
        #1;
        check("txn_access", {MemWrite, MemRead, Memory_Address},
              {wr && !exp_err, !wr && !exp_err, addr});
        @(negedge clock);
        #1;
        check("txn_rsp_own", port_rsp(port), {1'b1, exp_err, exp_rdata});
        check("txn_rsp_other", port_rsp(!port), 66'd0);
        if (wr && !exp_err) ref_write(addr, wdata);
        @(negedge clock);
        #1;
        check("txn_rsp_pulse", {p_if.rsp_valid, d_if.rsp_valid}, 2'b00);
    endtask

    typedef struct {
        logic        port;
        logic        wr;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic        err;
        logic [63:0] rdata;
    } vec_t;

    vec_t vecs [9];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  exp_g;
        logic        last_g;
        logic        acc_port;
        logic        acc_wr;
        logic        acc_err;
        logic        just_acc;
        logic [63:0] acc_rdata;
        logic [63:0] a;
        int          since;

        vecs[0] = '{REQ_PIPE, 1'b1, 64'd16, 64'h1122334455667788, 1'b0, 64'd0};
        vecs[1] = '{REQ_PIPE, 1'b0, 64'd16, 64'd0, 1'b0, 64'h1122334455667788};
        vecs[2] = '{REQ_DBG,  1'b1, 64'd193, 64'hDEADBEEF00000001, 1'b1, 64'd0};
        vecs[3] = '{REQ_DBG,  1'b0, 64'd192, 64'd0, 1'b0, 64'hC7C6C5C4C3C2C1C0};
        vecs[4] = '{REQ_PIPE, 1'b1, 64'hFFFFFFFFFFFFFFFC, 64'h5555AAAA5555AAAA, 1'b1, 64'd0};
        vecs[5] = '{REQ_DBG,  1'b0, 64'hFFFFFFFFFFFFFFF8, 64'd0, 1'b1, 64'd0};
        vecs[6] = '{REQ_PIPE, 1'b1, 64'd3, 64'h0102030405060708, 1'b0, 64'd0};
        vecs[7] = '{REQ_DBG,  1'b0, 64'd0, 64'd0, 1'b0, 64'h0405060708020100};
        vecs[8] = '{REQ_PIPE, 1'b0, 64'd8, 64'd0, 1'b0, 64'h0F0E0D0C0B010203};

        for (int i = 0; i < int'(MemBytes); i++) ref_mem[i] = 8'(i);

        // Reset: requests present but nothing may be granted or strobed.
        reset_n = 1'b0;
        drive(REQ_PIPE, 1'b1, 1'b1, 64'd16, 64'h1);
        drive(REQ_DBG, 1'b1, 1'b0, 64'd24, 64'h0);
        @(negedge clock);
        #1;
        check("reset_ready", {p_if.ready, d_if.ready}, 2'b00);
        check("reset_strobes", {MemWrite, MemRead}, 2'b00);
        @(negedge clock);
        reset_n = 1'b1;
        drive(REQ_PIPE, 1'b0, 1'b0, '0, '0);
        drive(REQ_DBG, 1'b0, 1'b0, '0, '0);
        #1;
        check("reset_rsp", {port_rsp(REQ_PIPE), port_rsp(REQ_DBG)}, 132'd0);
        check("reset_addr", Memory_Address, 64'd0);

        for (int i = 0; i < 9; i++) begin
            @(negedge clock);
            run_txn(vecs[i].port, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                    vecs[i].err, vecs[i].rdata);
        end

        // Round-robin after reset: both ports hold load requests, grants P, D, P.
        do_reset();
        drive(REQ_PIPE, 1'b1, 1'b0, 64'd0, '0);
        drive(REQ_DBG, 1'b1, 1'b0, 64'd8, '0);
        for (int c = 0; c < 9; c++) begin
            #1;
            exp_g = (c == 0 || c == 6) ? 2'b01 : (c == 3) ? 2'b10 : 2'b00;
            check("rr_order", {d_if.ready, p_if.ready}, exp_g);
            @(negedge clock);
        end
        drive(REQ_PIPE, 1'b0, 1'b0, '0, '0);
        drive(REQ_DBG, 1'b0, 1'b0, '0, '0);
        repeat (2) @(negedge clock);

        // Lone requester holding valid: ready every third cycle, other port silent.
        drive(REQ_PIPE, 1'b1, 1'b0, 64'd40, '0);
        for (int c = 0; c < 9; c++) begin
            #1;
            check("solo_ready", {d_if.ready, p_if.ready}, (c % 3 == 0) ? 2'b01 : 2'b00);
            check("solo_other_rsp", port_rsp(REQ_DBG), 66'd0);
            @(negedge clock);
        end
        drive(REQ_PIPE, 1'b0, 1'b0, '0, '0);
        repeat (2) @(negedge clock);

        // Reset during ACCESS of a store to 8: dropped, no response.
        drive(REQ_PIPE, 1'b1, 1'b1, 64'd8, 64'hCAFEF00DCAFEF00D);
        #1;
        check("rst_mid_accept", p_if.ready, 1'b1);
        @(negedge clock);
        drive(REQ_PIPE, 1'b0, 1'b0, '0, '0);
        reset_n = 1'b0;
        #1;
        check("rst_mid_strobes", {MemWrite, MemRead, p_if.ready, d_if.ready}, 4'b0000);
        @(negedge clock);
        reset_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            check("rst_mid_no_rsp", {p_if.rsp_valid, d_if.rsp_valid, MemWrite}, 3'b000);
            @(negedge clock);
        end
        run_txn(REQ_PIPE, 1'b0, 64'd8, '0, 1'b0, ref_read(64'd8));

        // Random two-port traffic against the transaction-level model.
        do_reset();
        last_g    = REQ_DBG;
        since     = 3;
        just_acc  = 1'b0;
        acc_port  = REQ_PIPE;
        acc_wr    = 1'b0;
        acc_err   = 1'b0;
        acc_rdata = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (cyc != 0) @(negedge clock);
            if (just_acc) drive(acc_port, 1'b0, 1'b0, '0, '0);
            just_acc = 1'b0;
            for (int pt = 0; pt < 2; pt++) begin
                if (!((pt == 1) ? d_if.valid : p_if.valid) && $urandom_range(0, 2) != 0) begin
                    if ($urandom_range(0, 9) == 0)
                        a = 64'hFFFFFFFFFFFFFFF0 | 64'($urandom_range(0, 15));
                    else
                        a = 64'($urandom_range(0, 205));
                    drive(pt[0], 1'b1, 1'($urandom_range(0, 1)), a, {$urandom, $urandom});
                end
            end
            #1;
            exp_g = 2'b00;
            if (since >= 3) begin
                if (p_if.valid && d_if.valid) exp_g = (last_g == REQ_DBG) ? 2'b01 : 2'b10;
                else if (p_if.valid)          exp_g = 2'b01;
                else if (d_if.valid)          exp_g = 2'b10;
            end
            check("rand_ready", {d_if.ready, p_if.ready}, exp_g);
            check("rand_strobes", {MemWrite, MemRead},
                  {since == 1 && acc_wr && !acc_err, since == 1 && !acc_wr && !acc_err});
            check("rand_rsp_p", port_rsp(REQ_PIPE),
                  (since == 2 && acc_port == REQ_PIPE) ? {1'b1, acc_err, acc_rdata} : 66'd0);
            check("rand_rsp_d", port_rsp(REQ_DBG),
                  (since == 2 && acc_port == REQ_DBG) ? {1'b1, acc_err, acc_rdata} : 66'd0);
            if (exp_g != 2'b00) begin
                acc_port = exp_g[1];
                acc_wr   = acc_port ? d_if.write : p_if.write;
                a        = acc_port ? d_if.addr : p_if.addr;
                acc_err  = ref_oor(a);
                acc_rdata = (!acc_wr && !acc_err) ? ref_read(a) : 64'd0;
                if (acc_wr && !acc_err) ref_write(a, acc_port ? d_if.wdata : p_if.wdata);
                last_g   = acc_port;
                just_acc = 1'b1;
                since    = 0;
            end
            if (since < 100) since++;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
